xbar_switch: RTL and testbench

- Registered, arbitrated NoC router crossbar that replaces the static swap-controlled crossbar.
- Each output has its own round-robin arbiter.
- Uses wormhole packet locking: once an input wins an output, that input holds it from the head flit through the tail flit.
- Uses valid/ready handshakes on every input and output, with a one-flit output register per port. It sits between the router input buffers and the link drivers.

---
 rtl/xbar_pkg.sv | 15 +
 rtl/xbar_switch_if.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/xbar_switch.sv | 125 ++++++++++++
 tb/tb_xbar_switch.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the arbitrated crossbar.
package xbar_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } lock_state_e;

  localparam int DROP_CNT_W = 16;

  // Index width for an N-entry selector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/xbar_switch_if.sv
// Flit-level bus between the input buffers, the crossbar and the link drivers.
interface xbar_switch_if
  import xbar_pkg::*;
#(
  parameter int INPUTS    = 7,
  parameter int OUTPUTS   = 7,
  parameter int FLIT_SIZE = 32,
  parameter int DW        = $clog2(OUTPUTS)
);
  logic [INPUTS-1:0]                in_valid;
  logic [INPUTS-1:0][FLIT_SIZE-1:0] in_flit;
  logic [INPUTS-1:0][DW-1:0]        in_dest;
  logic [INPUTS-1:0]                in_tail;
  logic [INPUTS-1:0]                in_ready;
  logic [OUTPUTS-1:0]                out_valid;
  logic [OUTPUTS-1:0][FLIT_SIZE-1:0] out_flit;
  logic [OUTPUTS-1:0]                out_tail;
  logic [OUTPUTS-1:0]                out_ready;
  logic [DROP_CNT_W-1:0]             drop_count;

  modport slave (
    input  in_valid, in_flit, in_dest, in_tail, out_ready,
    output in_ready, out_valid, out_flit, out_tail, drop_count
  );

  modport master (
    output in_valid, in_flit, in_dest, in_tail, out_ready,
    input  in_ready, out_valid, out_flit, out_tail, drop_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins, searching cyclically.
// ptr moves past the winner only when a packet's final flit is granted.
module rr_arbiter #(
  parameter int N = 7,
  localparam int IW = xbar_pkg::idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          upd,
  input  logic          fin,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          any
);
  logic [IW-1:0] ptr;
  logic [N-1:0]  hi;

  // Lowest requester at/above ptr, falling back to lowest requester overall.
  always_comb begin
    hi   = '0;
    gidx = '0;
    gnt  = '0;
    any  = |req;
    for (int i = 0; i < N; i++) hi[i] = req[i] && (i >= int'(ptr));
    for (int i = N-1; i >= 0; i--) if (req[i]) gidx = IW'(i);
    for (int i = N-1; i >= 0; i--) if (hi[i]) gidx = IW'(i);
    if (any) gnt[gidx] = 1'b1;
  end

  // Advance the pointer past the winner once its packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (upd && fin) ptr <= (int'(gidx) == N-1) ? '0 : gidx + IW'(1);
  end
endmodule

// File: rtl/xbar_switch.sv
// Registered NoC crossbar with per-output round-robin arbitration and
// wormhole locking; out-of-range destinations are discarded and counted.
module xbar_switch
  import xbar_pkg::*;
#(
  parameter int INPUTS    = 7,
  parameter int OUTPUTS   = 7,
  parameter int FLIT_SIZE = 32,
  parameter int DW        = $clog2(OUTPUTS)
) (
  input logic          clk,
  input logic          rst_n,
  xbar_switch_if.slave bus
);
  localparam int IW = idx_w(INPUTS);

  lock_state_e                       lock_st [INPUTS];
  logic [INPUTS-1:0][DW-1:0]         lock_port;
  logic [INPUTS-1:0]                 oor, drop, acc;
  logic [OUTPUTS-1:0][INPUTS-1:0]    req, gnt;
  logic [OUTPUTS-1:0][IW-1:0]        gidx;
  logic [OUTPUTS-1:0]                any, eff, fin, owned;
  logic [OUTPUTS-1:0]                ov, ot;
  logic [OUTPUTS-1:0][FLIT_SIZE-1:0] oflit;
  logic [DROP_CNT_W-1:0]             dcnt, dcnt_nxt;
  logic [DROP_CNT_W:0]               sum;

  // Owned outputs listen only to their owner; free outputs see idle heads aimed at them.
  always_comb begin
    owned = '0;
    req   = '0;
    oor   = '0;
    for (int i = 0; i < INPUTS; i++) oor[i] = int'(bus.in_dest[i]) >= OUTPUTS;
    for (int p = 0; p < OUTPUTS; p++)
      for (int i = 0; i < INPUTS; i++)
        if (lock_st[i] == LOCKED && int'(lock_port[i]) == p) owned[p] = 1'b1;
    for (int p = 0; p < OUTPUTS; p++)
      for (int i = 0; i < INPUTS; i++)
        if (owned[p])
          req[p][i] = bus.in_valid[i] && lock_st[i] == LOCKED && int'(lock_port[i]) == p;
        else
          req[p][i] = bus.in_valid[i] && lock_st[i] == IDLE && int'(bus.in_dest[i]) == p;
  end

  for (genvar p = 0; p < OUTPUTS; p++) begin : g_out
    rr_arbiter #(.N(INPUTS)) u_arb (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[p]),
      .upd  (eff[p]),
      .fin  (fin[p]),
      .gnt  (gnt[p]),
      .gidx (gidx[p]),
      .any  (any[p])
    );
  end

  // A grant only counts when the output register can take the flit this cycle.
  always_comb begin
    eff = '0;
    fin = '0;
    for (int p = 0; p < OUTPUTS; p++) begin
      eff[p] = any[p] && (!ov[p] || bus.out_ready[p]);
      fin[p] = bus.in_tail[gidx[p]];
    end
  end

  // Consume on effective grant or while discarding an out-of-range packet.
  always_comb begin
    drop = '0;
    for (int i = 0; i < INPUTS; i++)
      drop[i] = bus.in_valid[i] && (lock_st[i] == DROP || (lock_st[i] == IDLE && oor[i]));
    acc = drop;
    for (int p = 0; p < OUTPUTS; p++) if (eff[p]) acc = acc | gnt[p];
  end

  assign bus.in_ready = rst_n ? acc : '0;

  // Saturating add of every flit discarded this cycle.
  always_comb begin
    sum = {1'b0, dcnt};
    for (int i = 0; i < INPUTS; i++) sum = sum + {{DROP_CNT_W{1'b0}}, drop[i]};
    dcnt_nxt = sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  end

  // Per-input wormhole lock: heads open it, tails close it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUTS; i++) lock_st[i] <= IDLE;
      lock_port <= '0;
    end else begin
      for (int i = 0; i < INPUTS; i++)
        if (acc[i]) begin
          if (bus.in_tail[i]) lock_st[i] <= IDLE;
          else if (lock_st[i] == IDLE) begin
            lock_st[i]   <= oor[i] ? DROP : LOCKED;
            lock_port[i] <= bus.in_dest[i];
          end
        end
    end
  end

  // One-flit output registers plus the drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov    <= '0;
      ot    <= '0;
      oflit <= '0;
      dcnt  <= '0;
    end else begin
      dcnt <= dcnt_nxt;
      for (int p = 0; p < OUTPUTS; p++)
        if (eff[p]) begin
          ov[p]    <= 1'b1;
          ot[p]    <= bus.in_tail[gidx[p]];
          oflit[p] <= bus.in_flit[gidx[p]];
        end else if (bus.out_ready[p]) ov[p] <= 1'b0;
    end
  end

  assign bus.out_valid  = ov;
  assign bus.out_tail   = ot;
  assign bus.out_flit   = oflit;
  assign bus.drop_count = dcnt;
endmodule

// File: tb/tb_xbar_switch.sv
// Directed scenarios plus a randomized run against a packet-level model.
module tb_xbar_switch;
  localparam int I = 7, O = 7, F = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbar_switch_if #(.INPUTS(I), .OUTPUTS(O), .FLIT_SIZE(F)) bus ();
  xbar_switch #(.INPUTS(I), .OUTPUTS(O), .FLIT_SIZE(F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;

  // reference model state
  int m_st [I];      // 0 head expected, 1 forwarding packet, 2 discarding packet
  int m_own [O];     // owning input or -1
  int m_ptr [O];
  logic [O-1:0] m_ov, m_ot;
  logic [F-1:0] m_of [O];
  int m_dc;
  logic [I-1:0] m_acc;

  task automatic clr_in();
    bus.in_valid = '0; bus.in_flit = '0; bus.in_dest = '0; bus.in_tail = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr_in();
    bus.out_ready = '1;
    bus.in_valid = '1;
    rst_n = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 7'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 7'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
    checks++; if (bus.out_flit !== '0) begin errors++; $display("FAIL reset_out_flit got %h want 0", bus.out_flit); end
    clr_in();
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    clr_in();
    bus.in_valid[0] = 1'b1; bus.in_flit[0] = 32'hA5A5_0001; bus.in_dest[0] = 3'd3; bus.in_tail[0] = 1'b1;
    #2;
    checks++; if (bus.in_ready !== 7'b0000001) begin errors++; $display("FAIL single_ready got %b want 0000001", bus.in_ready); end
    step(); clr_in();
    checks++; if (bus.out_valid !== 7'b0001000) begin errors++; $display("FAIL single_valid got %b want 0001000", bus.out_valid); end
    checks++; if (bus.out_flit[3] !== 32'hA5A5_0001 || bus.out_tail[3] !== 1'b1)
      begin errors++; $display("FAIL single_flit got %h/%b want a5a50001/1", bus.out_flit[3], bus.out_tail[3]); end
    step();
    checks++; if (bus.out_valid !== 7'b0) begin errors++; $display("FAIL single_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_contention();
    int order [6] = '{1, 2, 4, 1, 2, 4};
    logic [I-1:0] exp;
    clr_in();
    foreach (order[k]) if (k < 3) begin
      bus.in_valid[order[k]] = 1'b1; bus.in_dest[order[k]] = 3'd2;
      bus.in_tail[order[k]] = 1'b1; bus.in_flit[order[k]] = 32'(order[k]);
    end
    for (int c = 0; c < 6; c++) begin
      exp = '0; exp[order[c]] = 1'b1;
      #2;
      checks++; if (bus.in_ready !== exp) begin errors++; $display("FAIL contention_ready c=%0d got %b want %b", c, bus.in_ready, exp); end
      step();
      checks++; if (bus.out_valid[2] !== 1'b1 || bus.out_flit[2] !== 32'(order[c]))
        begin errors++; $display("FAIL contention_out c=%0d got %b/%h want 1/%h", c, bus.out_valid[2], bus.out_flit[2], order[c]); end
    end
    clr_in(); step();
  endtask

  task automatic test_wormhole();
    clr_in();
    bus.in_valid[6] = 1'b1; bus.in_dest[6] = 3'd5; bus.in_tail[6] = 1'b1; bus.in_flit[6] = 32'hC000_0006;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid[0] = 1'b1; bus.in_flit[0] = 32'hB000_0000 + 32'(k);
      bus.in_dest[0] = (k == 0) ? 3'd5 : 3'd1; bus.in_tail[0] = (k == 3);
      #2;
      checks++; if (bus.in_ready !== 7'b0000001) begin errors++; $display("FAIL worm_ready k=%0d got %b want 0000001", k, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 7'b0100000 || bus.out_flit[5] !== 32'hB000_0000 + 32'(k) || bus.out_tail[5] !== (k == 3))
        begin errors++; $display("FAIL worm_out k=%0d got %b/%h/%b", k, bus.out_valid, bus.out_flit[5], bus.out_tail[5]); end
    end
    bus.in_valid[0] = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 7'b1000000) begin errors++; $display("FAIL worm_next_ready got %b want 1000000", bus.in_ready); end
    step();
    checks++; if (bus.out_flit[5] !== 32'hC000_0006 || bus.out_valid[5] !== 1'b1)
      begin errors++; $display("FAIL worm_next_out got %b/%h want 1/c0000006", bus.out_valid[5], bus.out_flit[5]); end
    clr_in(); step();
  endtask

  task automatic test_backpressure();
    clr_in();
    bus.in_valid[3] = 1'b1; bus.in_dest[3] = 3'd2; bus.in_flit[3] = 32'hD000_0000; bus.in_tail[3] = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 7'b0001000) begin errors++; $display("FAIL bp_head_ready got %b want 0001000", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 7'b0000100 || bus.out_flit[2] !== 32'hD000_0000)
      begin errors++; $display("FAIL bp_head_out got %b/%h", bus.out_valid, bus.out_flit[2]); end
    bus.out_ready[2] = 1'b0; bus.in_flit[3] = 32'hD000_0001; bus.in_dest[3] = 3'd6;
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++; if (bus.in_ready !== 7'b0) begin errors++; $display("FAIL bp_stall_ready c=%0d got %b want 0", c, bus.in_ready); end
      step();
      checks++; if (bus.out_valid[2] !== 1'b1 || bus.out_flit[2] !== 32'hD000_0000)
        begin errors++; $display("FAIL bp_stall_out c=%0d got %b/%h want 1/d0000000", c, bus.out_valid[2], bus.out_flit[2]); end
    end
    bus.out_ready[2] = 1'b1;
    for (int k = 1; k < 3; k++) begin
      bus.in_flit[3] = 32'hD000_0000 + 32'(k); bus.in_tail[3] = (k == 2);
      #2;
      checks++; if (bus.in_ready !== 7'b0001000) begin errors++; $display("FAIL bp_rel_ready k=%0d got %b", k, bus.in_ready); end
      step();
      checks++; if (bus.out_flit[2] !== 32'hD000_0000 + 32'(k) || bus.out_tail[2] !== (k == 2))
        begin errors++; $display("FAIL bp_rel_out k=%0d got %h/%b", k, bus.out_flit[2], bus.out_tail[2]); end
    end
    clr_in(); step();
    checks++; if (bus.out_valid !== 7'b0) begin errors++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_drop();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid[3] = 1'b1; bus.in_dest[3] = 3'd7; bus.in_tail[3] = (k == 2); bus.in_flit[3] = 32'hDEAD_0000 + 32'(k);
      #2;
      checks++; if (bus.in_ready !== 7'b0001000) begin errors++; $display("FAIL drop_ready k=%0d got %b", k, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 7'b0) begin errors++; $display("FAIL drop_valid k=%0d got %b want 0", k, bus.out_valid); end
    end
    checks++; if (bus.drop_count !== 16'd3) begin errors++; $display("FAIL drop_count got %0d want 3", bus.drop_count); end
    clr_in();
  endtask

  task automatic test_reset_mid();
    clr_in();
    for (int k = 0; k < 2; k++) begin
      bus.in_valid[0] = 1'b1; bus.in_dest[0] = 3'd5; bus.in_tail[0] = 1'b0; bus.in_flit[0] = 32'hE000_0000 + 32'(k);
      #2;
      checks++; if (bus.in_ready !== 7'b0000001) begin errors++; $display("FAIL rmid_ready k=%0d got %b", k, bus.in_ready); end
      step();
    end
    checks++; if (bus.out_valid !== 7'b0100000) begin errors++; $display("FAIL rmid_pre got %b want 0100000", bus.out_valid); end
    bus.in_flit[0] = 32'hE000_0002; bus.in_dest[0] = 3'd1; bus.in_tail[0] = 1'b1;
    #2; rst_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 7'b0 || bus.drop_count !== 16'd0 || bus.in_ready !== 7'b0)
      begin errors++; $display("FAIL rmid_async got %b/%0d/%b want 0", bus.out_valid, bus.drop_count, bus.in_ready); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    #2;
    checks++; if (bus.in_ready !== 7'b0000001) begin errors++; $display("FAIL rmid_head_ready got %b", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 7'b0000010 || bus.out_flit[1] !== 32'hE000_0002)
      begin errors++; $display("FAIL rmid_head_out got %b/%h want 0000010/e0000002", bus.out_valid, bus.out_flit[1]); end
    clr_in(); step();
  endtask

  // One cycle of the packet-level model: decide acceptances from the current state, then commit.
  task automatic model_cycle();
    int st0 [I];
    int w;
    logic cap;
    st0 = m_st;
    m_acc = '0;
    for (int p = 0; p < O; p++) begin
      cap = !m_ov[p] || bus.out_ready[p];
      w = -1;
      if (m_own[p] >= 0) begin
        if (bus.in_valid[m_own[p]]) w = m_own[p];
      end else begin
        for (int k = 0; k < I; k++) begin
          int c = (m_ptr[p] + k) % I;
          if (w < 0 && bus.in_valid[c] && st0[c] == 0 && int'(bus.in_dest[c]) == p) w = c;
        end
      end
      if (w >= 0 && cap) begin
        m_acc[w] = 1'b1; m_ov[p] = 1'b1; m_of[p] = bus.in_flit[w]; m_ot[p] = bus.in_tail[w];
        if (bus.in_tail[w]) begin m_own[p] = -1; m_ptr[p] = (w + 1) % I; m_st[w] = 0; end
        else begin m_own[p] = w; m_st[w] = 1; end
      end else if (bus.out_ready[p]) m_ov[p] = 1'b0;
    end
    for (int i = 0; i < I; i++)
      if (bus.in_valid[i] && (st0[i] == 2 || (st0[i] == 0 && int'(bus.in_dest[i]) >= O))) begin
        m_acc[i] = 1'b1;
        if (m_dc < 65535) m_dc++;
        m_st[i] = bus.in_tail[i] ? 0 : 2;
      end
  endtask

  task automatic test_random();
    int g_dest [I], g_len [I], g_idx [I], g_seq [I];
    clr_in();
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    step();
    for (int i = 0; i < I; i++) begin
      m_st[i] = 0; g_idx[i] = 0; g_seq[i] = 0; g_len[i] = $urandom_range(1, 4);
      g_dest[i] = ($urandom_range(0, 9) == 0) ? 7 : ($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(0, 6));
    end
    for (int p = 0; p < O; p++) begin m_own[p] = -1; m_ptr[p] = 0; m_of[p] = '0; end
    m_ov = '0; m_ot = '0; m_dc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < I; i++) begin
        bus.in_valid[i] = ($urandom_range(0, 3) != 0);
        bus.in_flit[i]  = {4'(i), 28'(g_seq[i])};
        bus.in_dest[i]  = (g_idx[i] == 0) ? 3'(g_dest[i]) : 3'($urandom_range(0, 7));
        bus.in_tail[i]  = (g_idx[i] == g_len[i] - 1);
      end
      for (int p = 0; p < O; p++) bus.out_ready[p] = ($urandom_range(0, 3) != 0);
      #2;
      model_cycle();
      checks++; if (bus.in_ready !== m_acc) begin errors++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, bus.in_ready, m_acc); end
      for (int i = 0; i < I; i++)
        if (m_acc[i]) begin
          g_seq[i]++; g_idx[i]++;
          if (g_idx[i] == g_len[i]) begin
            g_idx[i] = 0; g_len[i] = $urandom_range(1, 4);
            g_dest[i] = ($urandom_range(0, 9) == 0) ? 7 : ($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(0, 6));
          end
        end
      step();
      checks++; if (bus.out_valid !== m_ov || bus.out_tail !== m_ot)
        begin errors++; $display("FAIL rand_vt cyc=%0d got %b/%b want %b/%b", cyc, bus.out_valid, bus.out_tail, m_ov, m_ot); end
      for (int p = 0; p < O; p++) begin
        checks++; if (bus.out_flit[p] !== m_of[p]) begin errors++; $display("FAIL rand_flit cyc=%0d p=%0d got %h want %h", cyc, p, bus.out_flit[p], m_of[p]); end
      end
      checks++; if (int'(bus.drop_count) != m_dc) begin errors++; $display("FAIL rand_drop cyc=%0d got %0d want %0d", cyc, bus.drop_count, m_dc); end
    end
    clr_in();
    bus.out_ready = '1;
  endtask

  initial begin
    clr_in();
    bus.out_ready = '1;
    #12;
    test_reset();
    test_single();
    test_contention();
    test_wormhole();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
